// File: rtl/btn_event_decoder_pkg.sv
// rtl/btn_event_decoder_pkg.sv - shared state encodings, widths and helpers for the button event decoder
package btn_event_decoder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_HELD    = 2'd2
    } btn_state_e;

    localparam int MS_W   = 16;
    localparam int RCNT_W = 8;

    function automatic logic [RCNT_W-1:0] sat_inc(input logic [RCNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/btn_event_decoder_ms_tick_gen.sv
// rtl/btn_event_decoder_ms_tick_gen.sv - free-running 1 ms tick divider with synchronous restart
module ms_tick_gen #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = (cnt_q == LAST);
        cnt_d = cnt_q + 1'b1;
        // Restarting on the press edge keeps ms timing exact relative to the press
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/btn_event_decoder.sv
// rtl/btn_event_decoder.sv - turns a debounced button level into press/release/long/repeat pulses
module btn_event_decoder
    import btn_event_decoder_pkg::*;
#(
    parameter int TICK_DIV  = 50000,
    parameter int LONG_MS   = 500,
    parameter int REPEAT_MS = 100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              level_in,
    output logic              press_pulse,
    output logic              release_pulse,
    output logic              long_pulse,
    output logic              repeat_pulse,
    output logic              held,
    output logic [RCNT_W-1:0] repeat_cnt
);

    localparam logic [MS_W-1:0] LONG_THR   = MS_W'(LONG_MS - 1);
    localparam logic [MS_W-1:0] REPEAT_THR = MS_W'(REPEAT_MS - 1);

    logic s1_q, s2_q, s2d_q;
    logic rise, fall, press_clr, tick;

    btn_state_e        state_q, state_d;
    logic [MS_W-1:0]   ms_q, ms_d;
    logic [RCNT_W-1:0] rcnt_q, rcnt_d;
    logic press_q, press_d;
    logic release_q, release_d;
    logic long_q, long_d;
    logic repeat_q, repeat_d;
    logic held_q, held_d;

    assign rise      = s2_q & ~s2d_q;
    assign fall      = ~s2_q & s2d_q;
    assign press_clr = (state_q == ST_IDLE) && rise;

    ms_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (press_clr),
        .tick (tick)
    );

    always_comb begin
        state_d   = state_q;
        ms_d      = ms_q;
        rcnt_d    = rcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESSED;
                    press_d = 1'b1;
                    rcnt_d  = '0;
                    ms_d    = '0;
                end
            end
            ST_PRESSED: begin
                // A release in the threshold cycle takes priority over long
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (ms_q == LONG_THR) begin
                        state_d = ST_HELD;
                        long_d  = 1'b1;
                        ms_d    = '0;
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            ST_HELD: begin
                if (fall) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if (tick) begin
                    if (ms_q == REPEAT_THR) begin
                        repeat_d = 1'b1;
                        ms_d     = '0;
                        rcnt_d   = sat_inc(rcnt_q);
                    end else begin
                        ms_d = ms_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        held_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q      <= 1'b0;
            s2_q      <= 1'b0;
            s2d_q     <= 1'b0;
            state_q   <= ST_IDLE;
            ms_q      <= '0;
            rcnt_q    <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            s1_q      <= level_in;
            s2_q      <= s1_q;
            s2d_q     <= s2_q;
            state_q   <= state_d;
            ms_q      <= ms_d;
            rcnt_q    <= rcnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign release_pulse = release_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign held          = held_q;
    assign repeat_cnt    = rcnt_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb/tb_btn_event_decoder.sv - scoreboard bench for btn_event_decoder
module tb_btn_event_decoder;

    localparam int K_PRESS   = 0;
    localparam int K_RELEASE = 1;
    localparam int K_LONG    = 2;
    localparam int K_REPEAT  = 3;

    typedef struct {
        int kind;
        int cyc;
        int rcnt;
    } ev_t;

    logic       clk;
    logic       rst;
    logic       level_in;
    logic       press_pulse;
    logic       release_pulse;
    logic       long_pulse;
    logic       repeat_pulse;
    logic       held;
    logic [7:0] repeat_cnt;

    int  tests;
    int  fails;
    int  cyc;
    ev_t exp_q[$];

    btn_event_decoder #(
        .TICK_DIV  (4),
        .LONG_MS   (3),
        .REPEAT_MS (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .level_in      (level_in),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .long_pulse    (long_pulse),
        .repeat_pulse  (repeat_pulse),
        .held          (held),
        .repeat_cnt    (repeat_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Each observed pulse pops the next expected event
    always @(negedge clk) begin
        int  n;
        int  kind;
        ev_t e;
        n = int'(press_pulse === 1'b1) + int'(release_pulse === 1'b1)
          + int'(long_pulse === 1'b1) + int'(repeat_pulse === 1'b1);
        if (n > 0) begin
            kind = (press_pulse === 1'b1)   ? K_PRESS :
                   (release_pulse === 1'b1) ? K_RELEASE :
                   (long_pulse === 1'b1)    ? K_LONG : K_REPEAT;
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_event kind=%0d at cyc=%0d, none expected", kind, cyc);
            end else begin
                e = exp_q.pop_front();
                if (e.kind !== kind || e.cyc !== cyc || n != 1 ||
                    (kind == K_REPEAT && e.rcnt !== int'(repeat_cnt))) begin
                    fails++;
                    $display("FAIL event got kind=%0d cyc=%0d pulses=%0d rcnt=%0d, want kind=%0d cyc=%0d pulses=1 rcnt=%0d",
                             kind, cyc, n, repeat_cnt, e.kind, e.cyc, e.rcnt);
                end
            end
        end
    end

    function automatic void push(input int kind, input int c, input int r);
        ev_t e;
        e.kind = kind;
        e.cyc  = c;
        e.rcnt = r;
        exp_q.push_back(e);
    endfunction

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    task automatic drain(input string name);
        step(3);
        tests++;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL %s_missing_events got %0d pending, want 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        step(2);
        @(negedge clk);
        tests++; if (press_pulse !== 1'b0)   begin fails++; $display("FAIL reset_press got %b want 0", press_pulse); end
        tests++; if (release_pulse !== 1'b0) begin fails++; $display("FAIL reset_release got %b want 0", release_pulse); end
        tests++; if (long_pulse !== 1'b0)    begin fails++; $display("FAIL reset_long got %b want 0", long_pulse); end
        tests++; if (repeat_pulse !== 1'b0)  begin fails++; $display("FAIL reset_repeat got %b want 0", repeat_pulse); end
        tests++; if (held !== 1'b0)          begin fails++; $display("FAIL reset_held got %b want 0", held); end
        tests++; if (repeat_cnt !== 8'd0)    begin fails++; $display("FAIL reset_rcnt got %0d want 0", repeat_cnt); end
        step(1);
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_short_press();
        int n;
        int hc;
        step(1);
        n = cyc;
        push(K_PRESS, n + 3, 0);
        push(K_RELEASE, n + 11, 0);
        level_in = 1'b1;
        hc = 0;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 8) level_in = 1'b0;
            @(negedge clk);
            if (held === 1'b1) hc++;
        end
        tests++;
        if (hc != 8) begin
            fails++;
            $display("FAIL short_held_cycles got %0d want 8", hc);
        end
        drain("short");
    endtask

    task automatic test_long_hold();
        int t;
        step(1);
        t = cyc + 3;
        push(K_PRESS, t, 0);
        push(K_LONG, t + 12, 0);
        push(K_REPEAT, t + 20, 1);
        push(K_REPEAT, t + 28, 2);
        push(K_REPEAT, t + 36, 3);
        push(K_RELEASE, t + 41, 0);
        level_in = 1'b1;
        wait_cyc(t + 38);
        level_in = 1'b0;
        wait_cyc(t + 46);
        @(negedge clk);
        tests++;
        if (repeat_cnt !== 8'd3) begin fails++; $display("FAIL long_rcnt_hold got %0d want 3", repeat_cnt); end
        tests++;
        if (held !== 1'b0) begin fails++; $display("FAIL long_held_after got %b want 0", held); end
        drain("long");
    endtask

    task automatic test_release_on_threshold();
        int n;
        int t;
        step(1);
        n = cyc;
        t = n + 3;
        push(K_PRESS, t, 0);
        push(K_RELEASE, t + 12, 0);
        level_in = 1'b1;
        wait_cyc(n + 12);
        level_in = 1'b0;
        wait_cyc(t + 14);
        @(negedge clk);
        tests++;
        if (repeat_cnt !== 8'd0) begin fails++; $display("FAIL thr_rcnt_cleared got %0d want 0", repeat_cnt); end
        tests++;
        if (held !== 1'b0) begin fails++; $display("FAIL thr_held got %b want 0", held); end
        wait_cyc(t + 30);
        drain("threshold");
    endtask

    task automatic test_reset_in_held();
        int t;
        step(1);
        t = cyc + 3;
        push(K_PRESS, t, 0);
        push(K_LONG, t + 12, 0);
        push(K_REPEAT, t + 20, 1);
        push(K_PRESS, t + 26, 0);
        push(K_RELEASE, t + 33, 0);
        level_in = 1'b1;
        wait_cyc(t + 22);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        tests++;
        if (held !== 1'b0) begin fails++; $display("FAIL rst_held got %b want 0", held); end
        tests++;
        if (repeat_cnt !== 8'd0) begin fails++; $display("FAIL rst_rcnt got %0d want 0", repeat_cnt); end
        wait_cyc(t + 30);
        level_in = 1'b0;
        wait_cyc(t + 38);
        drain("rst_held");
    endtask

    task automatic test_saturation();
        int t;
        step(1);
        t = cyc + 3;
        push(K_PRESS, t, 0);
        push(K_LONG, t + 12, 0);
        for (int i = 1; i <= 300; i++) begin
            push(K_REPEAT, t + 12 + 8 * i, (i > 255) ? 255 : i);
        end
        push(K_RELEASE, t + 2417, 0);
        level_in = 1'b1;
        wait_cyc(t + 2414);
        level_in = 1'b0;
        wait_cyc(t + 2420);
        @(negedge clk);
        tests++;
        if (repeat_cnt !== 8'd255) begin fails++; $display("FAIL sat_rcnt got %0d want 255", repeat_cnt); end
        drain("sat");
    endtask

    task automatic test_back_to_back();
        int n;
        step(1);
        n = cyc;
        push(K_PRESS, n + 3, 0);
        push(K_RELEASE, n + 8, 0);
        push(K_PRESS, n + 9, 0);
        push(K_LONG, n + 21, 0);
        push(K_RELEASE, n + 25, 0);
        level_in = 1'b1;
        wait_cyc(n + 5);
        level_in = 1'b0;
        step(1);
        level_in = 1'b1;
        wait_cyc(n + 22);
        level_in = 1'b0;
        wait_cyc(n + 30);
        drain("b2b");
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        cyc      = 0;
        rst      = 1'b1;
        level_in = 1'b0;
        test_reset();
        test_short_press();
        test_long_hold();
        test_release_on_threshold();
        test_reset_in_held();
        test_saturation();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
